// File: rtl/tnn_neuron_seq.sv
// tnn_neuron_seq
//   Time-multiplexes one shared combinational TNN neuron core across the NEURONS
//   neurons of a layer. A frame is latched from the layer input buffer. Each neuron's
//   OP_W-bit operand slice is then presented to the core in turn. The 1-bit results
//   are collected into out_bits, which is handed on with a ready/valid handshake.
//
// Optional feature (compile-time macro TNN_SEQ_CORE_REG_EN):
//   When defined, the core is assumed registered. core_out is sampled one cycle after
//   the matching core_in, so issue and capture run as a two-stage pipeline. EVAL then
//   lasts NEURONS+1 cycles.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   frame handshake; in_data carries NEURONS operand slices
//   abort               discards a frame still in EVAL
//   core_in/core_out    operand bus to / result from the shared neuron core
//   out_valid/out_ready result handshake; out_bits[k] = result of neuron k
//   busy                high while a frame is in EVAL or DONE
module tnn_neuron_seq #(
   parameter int unsigned NEURONS = 4,
   parameter int unsigned N_IN    = 6,
   parameter int unsigned IN_W    = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NEURONS*N_IN*IN_W-1:0] in_data,
   input  logic                      abort,
   output logic [N_IN*IN_W-1:0]      core_in,
   input  logic                      core_out,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NEURONS-1:0]        out_bits,
   output logic                      busy
);

   localparam int unsigned OP_W  = N_IN * IN_W;
   localparam int unsigned IDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

   typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

   state_e                    state_q, state_d;
   logic [NEURONS*OP_W-1:0]   frame_q, frame_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [NEURONS-1:0]        bits_q, bits_d;
   logic [OP_W-1:0]           slices [NEURONS];

`ifdef TNN_SEQ_CORE_REG_EN
   // issue_q: idx_q still has a slice to present.
   // pend_q:  a result for pidx_q arrives on core_out this cycle.
   logic                      issue_q, issue_d;
   logic                      pend_q, pend_d;
   logic [IDX_W-1:0]          pidx_q, pidx_d;
`endif

   for (genvar k = 0; k < NEURONS; k++) begin : g_slice
      assign slices[k] = frame_q[k*OP_W +: OP_W];
   end

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      idx_d     = idx_q;
      bits_d    = bits_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      core_in   = '0;
`ifdef TNN_SEQ_CORE_REG_EN
      issue_d   = issue_q;
      pend_d    = pend_q;
      pidx_d    = pidx_q;
`endif
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               frame_d = in_data;
               idx_d   = '0;
               bits_d  = '0;
               state_d = StEval;
`ifdef TNN_SEQ_CORE_REG_EN
               issue_d = 1'b1;
               pend_d  = 1'b0;
`endif
            end
         end
         StEval: begin
            busy = 1'b1;
`ifdef TNN_SEQ_CORE_REG_EN
            if (issue_q) begin
               core_in = slices[idx_q];
               pend_d  = 1'b1;
               pidx_d  = idx_q;
               if (idx_q == LAST_IDX) begin
                  issue_d = 1'b0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               pend_d = 1'b0;
            end
            if (pend_q) begin
               bits_d[pidx_q] = core_out;
               if (pidx_q == LAST_IDX) begin
                  state_d = StDone;
               end
            end
`else
            core_in        = slices[idx_q];
            bits_d[idx_q]  = core_out;
            if (idx_q == LAST_IDX) begin
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
`endif
            // abort wins over completion and squashes any capture in flight.
            if (abort) begin
               state_d = StIdle;
               bits_d  = '0;
               idx_d   = '0;
`ifdef TNN_SEQ_CORE_REG_EN
               issue_d = 1'b0;
               pend_d  = 1'b0;
`endif
            end
         end
         StDone: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         frame_q <= '0;
         idx_q   <= '0;
         bits_q  <= '0;
`ifdef TNN_SEQ_CORE_REG_EN
         issue_q <= 1'b0;
         pend_q  <= 1'b0;
         pidx_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         idx_q   <= idx_d;
         bits_q  <= bits_d;
`ifdef TNN_SEQ_CORE_REG_EN
         issue_q <= issue_d;
         pend_q  <= pend_d;
         pidx_q  <= pidx_d;
`endif
      end
   end

   assign out_bits = bits_q;

endmodule

// File: tb/tb_tnn_neuron_seq.sv
// tb_tnn_neuron_seq
//   Self-checking bench for tnn_neuron_seq. The core stub computes
//   core_out = ^core_in. The stub is registered when TNN_SEQ_CORE_REG_EN is defined.
//   Expected results come from the parity of each neuron's operand slice.
module tb_tnn_neuron_seq;

   localparam int unsigned NEURONS = 4;
   localparam int unsigned N_IN    = 6;
   localparam int unsigned IN_W    = 3;
   localparam int unsigned OP_W    = N_IN * IN_W;
   localparam int unsigned DW      = NEURONS * OP_W;
`ifdef TNN_SEQ_CORE_REG_EN
   localparam int LAT = NEURONS + 2;
`else
   localparam int LAT = NEURONS + 1;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [DW-1:0]      in_data = '0;
   logic               abort = 1'b0;
   logic [OP_W-1:0]    core_in;
   logic               core_out;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [NEURONS-1:0] out_bits;
   logic               busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

`ifdef TNN_SEQ_CORE_REG_EN
   logic core_r = 1'b0;
   always @(posedge clk) core_r <= ^core_in;
   assign core_out = core_r;
`else
   assign core_out = ^core_in;
`endif

   tnn_neuron_seq #(
      .NEURONS (NEURONS),
      .N_IN    (N_IN),
      .IN_W    (IN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .abort     (abort),
      .core_in   (core_in),
      .core_out  (core_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: each output bit is the parity of that neuron's operand slice.
   function automatic logic [NEURONS-1:0] model(input logic [DW-1:0] d);
      logic [NEURONS-1:0] r;
      for (int k = 0; k < NEURONS; k++) begin
         logic p;
         p = 1'b0;
         for (int j = 0; j < OP_W; j++) p = p ^ d[k*OP_W + j];
         r[k] = p;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_frame();
      logic [DW-1:0] d;
      for (int i = 0; i < DW; i++) d[i] = 1'($urandom_range(0, 1));
      return d;
   endfunction

   // Build a frame whose per-neuron slice parities equal par.
   function automatic logic [DW-1:0] frame_with_parity(input logic [NEURONS-1:0] par);
      logic [DW-1:0] d;
      d = rand_frame();
      for (int k = 0; k < NEURONS; k++) begin
         if (model(d)[k] != par[k]) d[k*OP_W] = ~d[k*OP_W];
      end
      return d;
   endfunction

   // Presents a frame (already in IDLE) and waits for out_valid; checks latency and bits.
   task automatic run_frame(input string tag, input logic [DW-1:0] d);
      int cnt;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
      in_data  = rand_frame();
      cnt = 1;
      while (!out_valid && cnt < 50) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) check({tag, "_eval_flags"}, {in_ready, busy}, 32'b01);
         step();
         cnt++;
      end
      check({tag, "_latency"}, 32'(cnt), 32'(LAT));
      check({tag, "_bits"}, 32'(out_bits), 32'(model(d)));
   endtask

   initial begin
      logic [DW-1:0] fa, fb;
      logic [NEURONS-1:0] held;
      int cnt;
      bit seen;

      // 1. reset values
      step();
      step();
      rst = 1'b0;
      step();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_bits", 32'(out_bits), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_core_in", 32'(core_in), 32'd0);

      // 2. parity pattern 1011, out_ready high: one-cycle out_valid
      out_ready = 1'b1;
      run_frame("t2", frame_with_parity(4'b1011));
      check("t2_value", 32'(out_bits), 32'hB);
      step();
      check("t2_valid_drop", 32'(out_valid), 32'd0);
      check("t2_idle", 32'(in_ready), 32'd1);
      check("t2_core_in_idle", 32'(core_in), 32'd0);

      // 3. back-pressure for 10 cycles, then immediate second frame
      out_ready = 1'b0;
      fa = rand_frame();
      run_frame("t3", fa);
      held = out_bits;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t3_hold_valid", 32'(out_valid), 32'd1);
         check("t3_hold_bits", 32'(out_bits), 32'(model(fa)));
         check("t3_hold_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      check("t3_after_hs", 32'({in_ready, out_valid}), 32'b10);
      run_frame("t3b", rand_frame());
      step();

      // 4. in_valid held through EVAL with different data
      fa = rand_frame();
      fb = ~fa ^ rand_frame();
      in_valid = 1'b1;
      in_data  = fa;
      step();
      in_data  = fb;
      cnt = 1;
      while (!out_valid && cnt < 50) begin
         step();
         cnt++;
      end
      check("t4_latency", 32'(cnt), 32'(LAT));
      check("t4_first_bits", 32'(out_bits), 32'(model(fa)));
      step();
      check("t4_idle_accept", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("t4_second_busy", 32'(busy), 32'd1);
      cnt = 1;
      while (!out_valid && cnt < 50) begin
         step();
         cnt++;
      end
      check("t4_second_latency", 32'(cnt), 32'(LAT));
      check("t4_second_bits", 32'(out_bits), 32'(model(fb)));
      step();

      // 5. abort at EVAL cycle 2
      in_valid = 1'b1;
      in_data  = frame_with_parity(4'b1111);
      step();
      in_valid = 1'b0;
      step();
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t5_idle", 32'({in_ready, busy}), 32'b10);
      check("t5_bits_cleared", 32'(out_bits), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b0) seen = 1'b1;
         step();
      end
      check("t5_no_valid", 32'(seen), 32'd0);
      run_frame("t5_next", frame_with_parity(4'b0100));
      step();

      // 6. asynchronous reset mid-EVAL
      in_valid = 1'b1;
      in_data  = rand_frame();
      step();
      in_valid = 1'b0;
      step();
      #2 rst = 1'b1;
      #1;
      check("t6_rst_outs", 32'({in_ready, out_valid, busy}), 32'b100);
      check("t6_rst_bits", 32'(out_bits), 32'd0);
      check("t6_rst_core_in", 32'(core_in), 32'd0);
      #1 rst = 1'b0;
      step();
      run_frame("t6_next", rand_frame());
      step();

      // Randomized frames with random back-pressure
      for (int n = 0; n < 16; n++) begin
         out_ready = 1'b0;
         fa = rand_frame();
         run_frame("rnd", fa);
         for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
            step();
            check("rnd_hold", 32'({out_valid, out_bits}), 32'({1'b1, model(fa)}));
         end
         out_ready = 1'b1;
         step();
         check("rnd_release", 32'({in_ready, out_valid}), 32'b10);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
